// File: rtl/vm_out_pkg.sv
// Shared types and defaults for the vending-machine output/change stage.
package vm_out_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RETURN = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int DEF_NUM_ITEMS = 4;
    localparam int DEF_NUM_COINS = 3;
    localparam int DEF_TOTAL_W   = 31;

    // Item i / coin k lives at [i*TOTAL_W +: TOTAL_W]; coins ascend by index.
    localparam logic [DEF_NUM_ITEMS*DEF_TOTAL_W-1:0] DEF_ITEM_PRICES =
        {31'd2000, 31'd1000, 31'd500, 31'd400};
    localparam logic [DEF_NUM_COINS*DEF_TOTAL_W-1:0] DEF_COIN_VALS =
        {31'd1000, 31'd500, 31'd100};

    localparam int VEC_MAX_W   = 1024;
    localparam int FIELD_MAX_W = 64;

    // Upper bits above w belong to the next field; callers truncate to their width.
    function automatic logic [FIELD_MAX_W-1:0] get_field(input logic [VEC_MAX_W-1:0] vec,
                                                         input int idx, input int w);
        logic [VEC_MAX_W-1:0] sh;
        sh = vec >> (idx * w);
        return sh[FIELD_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/vm_change_picker.sv
// Combinational greedy coin choice: largest coin whose value does not exceed the total.
module vm_change_picker
    import vm_out_pkg::*;
#(
    parameter int NUM_COINS = DEF_NUM_COINS,
    parameter int TOTAL_W   = DEF_TOTAL_W,
    parameter logic [NUM_COINS*TOTAL_W-1:0] COIN_VALS = DEF_COIN_VALS
) (
    input  logic [TOTAL_W-1:0]   total,
    output logic [NUM_COINS-1:0] coin_onehot,
    output logic [TOTAL_W-1:0]   coin_value,
    output logic                 found
);

    logic [TOTAL_W-1:0] coin_val [NUM_COINS];

    for (genvar g = 0; g < NUM_COINS; g++) begin : g_val
        assign coin_val[g] = TOTAL_W'(get_field(VEC_MAX_W'(COIN_VALS), g, TOTAL_W));
    end

    // Ascending scan: the last payable coin is the largest one.
    always_comb begin
        coin_onehot = '0;
        coin_value  = '0;
        found       = 1'b0;
        for (int k = 0; k < NUM_COINS; k++) begin
            if (coin_val[k] <= total) begin
                coin_onehot = NUM_COINS'(1) << k;
                coin_value  = coin_val[k];
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vm_output_sequencer.sv
// Vending output stage: registers item/total, derives availability, pays change one coin per cycle.
// Optional idle auto-return enabled by VM_RETURN_TIMEOUT_EN.
module vm_output_sequencer
    import vm_out_pkg::*;
#(
    parameter int NUM_ITEMS = DEF_NUM_ITEMS,
    parameter int NUM_COINS = DEF_NUM_COINS,
    parameter int TOTAL_W   = DEF_TOTAL_W,
    parameter logic [NUM_ITEMS*TOTAL_W-1:0] ITEM_PRICES = DEF_ITEM_PRICES,
    parameter logic [NUM_COINS*TOTAL_W-1:0] COIN_VALS   = DEF_COIN_VALS,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_ITEMS-1:0] i_output_item_nxt,
    input  logic [TOTAL_W-1:0]   i_total_nxt,
    input  logic                 i_return_req,
    output logic [NUM_ITEMS-1:0] o_available_item,
    output logic [NUM_ITEMS-1:0] o_output_item,
    output logic [NUM_COINS-1:0] o_return_coin,
    output logic [TOTAL_W-1:0]   o_current_total,
    output logic                 o_busy,
    output logic                 o_residual
);

    state_t state, state_nxt;

    logic [NUM_COINS-1:0] pick_onehot;
    logic [TOTAL_W-1:0]   pick_value;
    logic                 pick_found;
    logic [TOTAL_W-1:0]   total_after;
    logic                 timeout_hit;
    logic                 go_return;

    vm_change_picker #(
        .NUM_COINS (NUM_COINS),
        .TOTAL_W   (TOTAL_W),
        .COIN_VALS (COIN_VALS)
    ) u_picker (
        .total       (o_current_total),
        .coin_onehot (pick_onehot),
        .coin_value  (pick_value),
        .found       (pick_found)
    );

    assign total_after = o_current_total - pick_value;

`ifdef VM_RETURN_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] idle_cnt;
    logic             idle_quiet;

    // Quiet = money inserted but nothing changing and nothing being bought.
    assign idle_quiet  = (state == ST_IDLE) && (o_current_total != '0) &&
                         (i_total_nxt == o_current_total) && (i_output_item_nxt == '0);
    assign timeout_hit = idle_quiet && (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idle_cnt <= '0;
        end else if (idle_quiet && !go_return) begin
            idle_cnt <= idle_cnt + CNT_W'(1);
        end else begin
            idle_cnt <= '0;
        end
    end
`else
    // Timeout disabled: only an explicit request starts a return.
    assign timeout_hit = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

    assign go_return = i_return_req | timeout_hit;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (go_return) state_nxt = ST_RETURN;
            ST_RETURN: if (!pick_found || total_after == '0) state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= ST_IDLE;
            o_output_item   <= '0;
            o_return_coin   <= '0;
            o_current_total <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    o_return_coin <= '0;
                    if (go_return) begin
                        o_output_item <= '0;
                    end else begin
                        o_output_item   <= i_output_item_nxt;
                        o_current_total <= i_total_nxt;
                    end
                end
                ST_RETURN: begin
                    o_output_item <= '0;
                    o_return_coin <= pick_found ? pick_onehot : '0;
                    if (pick_found) o_current_total <= total_after;
                end
                default: begin
                    o_output_item   <= '0;
                    o_return_coin   <= '0;
                    o_current_total <= '0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_ITEMS; g++) begin : g_avail
        assign o_available_item[g] = (state == ST_IDLE) &&
            (o_current_total >= TOTAL_W'(get_field(VEC_MAX_W'(ITEM_PRICES), g, TOTAL_W)));
    end

    assign o_busy     = (state != ST_IDLE);
    assign o_residual = (state == ST_DONE) && (o_current_total != '0);

endmodule
